// File: rtl/fru_pkg.sv
// Shared definitions for the force/release override unit: command encodings,
// controller states and a small op-decoding helper.
package fru_pkg;

  typedef enum logic [1:0] {
    FRU_NOP     = 2'd0,
    FRU_FORCE   = 2'd1,
    FRU_RELEASE = 2'd2,
    FRU_REFORCE = 2'd3
  } fru_op_e;

  typedef enum logic [1:0] {
    ST_REL    = 2'd0,
    ST_FRC    = 2'd1,
    ST_SETTLE = 2'd2
  } fru_state_e;

  localparam int FRU_CNT_W = 16;

  // FORCE and REFORCE both (re)load the override value.
  function automatic logic fru_is_force(input logic [1:0] op);
    return (op == FRU_FORCE) || (op == FRU_REFORCE);
  endfunction

endpackage

// File: rtl/fru_sat_counter.sv
// Saturating up-counter with asynchronous reset and synchronous clear.
module fru_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/force_release_unit.sv
// Models a force/release override of a WIDTH-bit net with wire (IS_REG=0) or
// reg (IS_REG=1) release semantics. Define FRU_STATS_EN to add command counters.
module force_release_unit
  import fru_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int IS_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] drv_val,
  input  logic             drv_upd,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_val,
  output logic [WIDTH-1:0] eff_val,
  output logic             forced,
  output logic             rel_done
`ifdef FRU_STATS_EN
  ,
  output logic [FRU_CNT_W-1:0] force_cnt,
  output logic [FRU_CNT_W-1:0] release_cnt
`endif
);

  fru_state_e       r_state;
  fru_state_e       w_state_next;
  logic [WIDTH-1:0] r_eff;
  logic [WIDTH-1:0] w_eff_next;
  logic             r_ready_en;
  logic             w_accept;
  logic             w_force_cmd;
  logic             w_release_cmd;
  logic             w_drv_take;

  // Ready stays low through the first edge after reset so no command lands there.
  assign cmd_ready     = r_ready_en && (r_state != ST_SETTLE);
  assign w_accept      = cmd_valid && cmd_ready;
  assign w_force_cmd   = w_accept && fru_is_force(cmd_op);
  assign w_release_cmd = w_accept && (cmd_op == FRU_RELEASE);
  assign w_drv_take    = (IS_REG == 0) || drv_upd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_REL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // While forced, r_eff itself is the latched override value.
  always_comb begin
    w_state_next = r_state;
    w_eff_next   = r_eff;
    case (r_state)
      ST_REL: begin
        if (w_force_cmd) begin
          w_state_next = ST_FRC;
          w_eff_next   = cmd_val;
        end else if (w_drv_take) begin
          w_eff_next = drv_val;
        end
      end
      ST_FRC: begin
        if (w_force_cmd) begin
          w_eff_next = cmd_val;
        end else if (w_release_cmd) begin
          w_state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        w_state_next = ST_REL;
        if (w_drv_take) begin
          w_eff_next = drv_val;
        end
      end
      default: begin
        w_state_next = ST_REL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_eff      <= '0;
      r_ready_en <= 1'b0;
    end else begin
      r_eff      <= w_eff_next;
      r_ready_en <= 1'b1;
    end
  end

  assign eff_val  = r_eff;
  assign forced   = (r_state == ST_FRC);
  assign rel_done = (r_state == ST_SETTLE);

`ifdef FRU_STATS_EN
  fru_sat_counter #(
    .WIDTH(FRU_CNT_W)
  ) u_force_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_force_cmd),
    .clr (1'b0),
    .cnt (force_cnt)
  );

  // A release completes on the single SETTLE cycle.
  fru_sat_counter #(
    .WIDTH(FRU_CNT_W)
  ) u_release_cnt (
    .clk (clk),
    .rst (rst),
    .inc (r_state == ST_SETTLE),
    .clr (1'b0),
    .cnt (release_cnt)
  );
`endif

endmodule
